// File: rtl/i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_ctrl
// Single-master I2C transaction sequencer. One command per handshake:
// START, {addr,rw}, ACK slot, one data byte (write or read), ACK/NACK slot,
// STOP. Returns read data and acknowledge status on a one-cycle strobe.
//
// Ports
//   clk, rst_n           system clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (accepted when both high)
//   cmd_addr, cmd_rw     7-bit target address, 0 = write / 1 = read
//   cmd_wdata            byte to write (ignored on reads)
//   rsp_valid            one-cycle pulse when the transaction is finished
//   rsp_rdata            byte read from the bus (held until next read)
//   rsp_nack             1 = address or write-data slot was NACKed
//   busy                 transaction in progress
//   scl                  push-pull I2C clock
//   sda                  open-drain I2C data (driven 0 or released)
//
// Timing: every bus phase change happens on a quarter tick, one tick every
// DIV clocks while busy. A bit slot is four quarters q0..q3, with scl low in
// q0/q1 and high in q2/q3. SDA is updated on entry to q0 and sampled on the
// tick that ends q2.
// ---------------------------------------------------------------------------
module i2c_master_ctrl #(
    parameter int DIV   = 25,
    parameter int DIV_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl,
    inout  wire        sda
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_AACK  = 4'd3,
        ST_WDATA = 4'd4,
        ST_WACK  = 4'd5,
        ST_RDATA = 4'd6,
        ST_RNACK = 4'd7,
        ST_STOP  = 4'd8
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // Bus levels for a given phase, returned as {scl, sda_en}.
    // sda_en = 1 pulls SDA low; data bits are sent as ~bit.
    function automatic logic [1:0] bus_drive(input state_t st,
                                             input logic [1:0] qph,
                                             input logic data_bit);
        logic [1:0] r;
        r = 2'b10;
        case (st)
            ST_IDLE: r = 2'b10;
            ST_START: begin
                case (qph)
                    2'd0, 2'd1: r = 2'b10;
                    2'd2:       r = 2'b11;
                    2'd3:       r = 2'b01;
                    default:    r = 2'b10;
                endcase
            end
            ST_ADDR, ST_WDATA:                    r = {qph[1], ~data_bit};
            ST_AACK, ST_WACK, ST_RDATA, ST_RNACK: r = {qph[1], 1'b0};
            ST_STOP: begin
                case (qph)
                    2'd0:    r = 2'b01;
                    2'd1:    r = 2'b11;
                    default: r = 2'b10;
                endcase
            end
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    state_t           state_r, state_n;
    logic [1:0]       qph_r, qph_n;
    logic [2:0]       bitcnt_r, bitcnt_n;
    logic [7:0]       shift_r, shift_n;
    logic [7:0]       wdata_r, wdata_n;
    logic             rw_r, rw_n;
    logic [7:0]       rdata_r, rdata_n;
    logic             nack_r, nack_n;
    logic             rsp_valid_r, rsp_valid_n;
    logic             cmd_ready_r;
    logic             busy_r;
    logic             scl_r;
    logic             sda_en_r;
    logic [1:0]       bus_n;
    logic [DIV_W-1:0] qcnt_r;
    logic             tick_r;
    logic             sda_in_s;

    assign sda_in_s = sda;

    // Quarter-period counter: free-runs only while busy, one-clock tick on wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qcnt_r <= '0;
            tick_r <= 1'b0;
        end else if (!busy_r) begin
            qcnt_r <= '0;
            tick_r <= 1'b0;
        end else if (qcnt_r == DIV_LAST) begin
            qcnt_r <= '0;
            tick_r <= 1'b1;
        end else begin
            qcnt_r <= qcnt_r + DIV_W'(1);
            tick_r <= 1'b0;
        end
    end

    // Next-state, datapath and bus-level computation.
    always_comb begin
        state_n     = state_r;
        qph_n       = qph_r;
        bitcnt_n    = bitcnt_r;
        shift_n     = shift_r;
        wdata_n     = wdata_r;
        rw_n        = rw_r;
        rdata_n     = rdata_r;
        nack_n      = nack_r;
        rsp_valid_n = 1'b0;

        if (state_r == ST_IDLE) begin
            if (cmd_valid && cmd_ready_r) begin
                state_n  = ST_START;
                qph_n    = 2'd0;
                bitcnt_n = 3'd7;
                shift_n  = {cmd_addr, cmd_rw};
                wdata_n  = cmd_wdata;
                rw_n     = cmd_rw;
                nack_n   = 1'b0;
            end else begin
                state_n = ST_IDLE;
            end
        end else if (!tick_r) begin
            state_n = state_r;
        end else if (qph_r != 2'd3) begin
            qph_n = qph_r + 2'd1;
            // Tick ending q2: SCL is high and stable, sample the line.
            if (qph_r == 2'd2) begin
                case (state_r)
                    ST_AACK, ST_WACK: nack_n  = sda_in_s;
                    ST_RDATA:         rdata_n = {rdata_r[6:0], sda_in_s};
                    default:          nack_n  = nack_r;
                endcase
            end else begin
                nack_n = nack_r;
            end
        end else begin
            // End of a bit slot (or of the START/STOP quarter sequence).
            qph_n = 2'd0;
            case (state_r)
                ST_START: begin
                    state_n  = ST_ADDR;
                    bitcnt_n = 3'd7;
                end
                ST_ADDR: begin
                    if (bitcnt_r == 3'd0) begin
                        state_n = ST_AACK;
                    end else begin
                        bitcnt_n = bitcnt_r - 3'd1;
                        shift_n  = {shift_r[6:0], 1'b0};
                    end
                end
                ST_AACK: begin
                    if (nack_r) begin
                        state_n = ST_STOP;
                    end else if (rw_r) begin
                        state_n  = ST_RDATA;
                        bitcnt_n = 3'd7;
                    end else begin
                        state_n  = ST_WDATA;
                        bitcnt_n = 3'd7;
                        shift_n  = wdata_r;
                    end
                end
                ST_WDATA: begin
                    if (bitcnt_r == 3'd0) begin
                        state_n = ST_WACK;
                    end else begin
                        bitcnt_n = bitcnt_r - 3'd1;
                        shift_n  = {shift_r[6:0], 1'b0};
                    end
                end
                ST_WACK: state_n = ST_STOP;
                ST_RDATA: begin
                    if (bitcnt_r == 3'd0) begin
                        state_n = ST_RNACK;
                    end else begin
                        bitcnt_n = bitcnt_r - 3'd1;
                    end
                end
                ST_RNACK: state_n = ST_STOP;
                ST_STOP: begin
                    state_n     = ST_IDLE;
                    rsp_valid_n = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        // Bus levels follow the phase being entered, so they are registered
        // on the same edge as the state change.
        bus_n = bus_drive(state_n, qph_n, shift_n[7]);
    end

    // State, datapath and registered outputs. Reset releases the bus at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            qph_r       <= 2'd0;
            bitcnt_r    <= 3'd0;
            shift_r     <= 8'h00;
            wdata_r     <= 8'h00;
            rw_r        <= 1'b0;
            rdata_r     <= 8'h00;
            nack_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            scl_r       <= 1'b1;
            sda_en_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            qph_r       <= qph_n;
            bitcnt_r    <= bitcnt_n;
            shift_r     <= shift_n;
            wdata_r     <= wdata_n;
            rw_r        <= rw_n;
            rdata_r     <= rdata_n;
            nack_r      <= nack_n;
            rsp_valid_r <= rsp_valid_n;
            cmd_ready_r <= (state_n == ST_IDLE);
            busy_r      <= (state_n != ST_IDLE);
            scl_r       <= bus_n[1];
            sda_en_r    <= bus_n[0];
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_nack  = nack_r;
    assign scl       = scl_r;
    assign sda       = sda_en_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_ctrl
// Directed bench for i2c_master_ctrl (DIV = 4). A behavioural I2C slave
// watches the bus once per clock, detects START/STOP, captures the address
// and data bytes, and drives ACK / read data on falling SCL. Transactions
// come from a vector table; back-to-back handshake and mid-transaction reset
// are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_i2c_master_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl;
    wire        sda_w;

    int n_checks = 0;
    int n_err    = 0;

    // Slave configuration (written by the stimulus only)
    logic [6:0] sl_addr      = 7'h2A;
    logic       sl_present   = 1'b0;
    logic [7:0] sl_rdata     = 8'h00;
    logic       sl_nack_data = 1'b0;

    // Slave state and observations (written by the slave process only)
    logic       sl_drive  = 1'b0;
    logic       prev_scl  = 1'b1;
    logic       prev_sda  = 1'b1;
    logic       in_txn    = 1'b0;
    logic       addressed = 1'b0;
    int         bit_idx   = 0;
    logic [7:0] addr_byte = 8'h00;
    logic [7:0] data_byte = 8'h00;
    logic       mack      = 1'b0;
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         rsp_cnt   = 0;

    pullup (sda_w);
    assign sda_w = sl_drive ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.DIV(DIV), .DIV_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl       (scl),
        .sda       (sda_w)
    );

    always #5 clk = ~clk;

    // Count response pulses
    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
    end

    // Behavioural slave, sampling the bus between active clock edges
    always @(negedge clk) begin
        if (prev_scl && scl && prev_sda && !sda_w) begin
            start_cnt++;
            in_txn    = 1'b1;
            addressed = 1'b0;
            bit_idx   = 0;
            addr_byte = 8'h00;
            data_byte = 8'h00;
            mack      = 1'b0;
            sl_drive  = 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda_w) begin
            stop_cnt++;
            in_txn   = 1'b0;
            sl_drive = 1'b0;
        end else if (in_txn && !prev_scl && scl) begin
            if (bit_idx < 8) addr_byte = {addr_byte[6:0], sda_w};
            else if (bit_idx >= 9 && bit_idx <= 16) data_byte = {data_byte[6:0], sda_w};
            else if (bit_idx == 17) mack = sda_w;
            bit_idx++;
        end else if (in_txn && prev_scl && !scl) begin
            sl_drive = 1'b0;
            if (bit_idx == 8 && sl_present && addr_byte[7:1] == sl_addr) begin
                addressed = 1'b1;
                sl_drive  = 1'b1;
            end else if (addressed && addr_byte[0] && bit_idx >= 9 && bit_idx <= 16) begin
                sl_drive = !sl_rdata[16 - bit_idx];
            end else if (addressed && !addr_byte[0] && bit_idx == 17) begin
                sl_drive = !sl_nack_data;
            end
        end
        prev_scl = scl;
        prev_sda = sda_w;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       present;
        logic       nack_data;
        logic [7:0] sl_rdata;
        int         exp_cyc;
        logic       exp_nack;
        logic [7:0] exp_rdata;
        logic [7:0] exp_abyte;
    } vec_t;

    vec_t vecs[8];

    task automatic run_txn(input vec_t v, input string tag);
        int cyc;
        int s0;
        int p0;
        sl_present   = v.present;
        sl_rdata     = v.sl_rdata;
        sl_nack_data = v.nack_data;
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_rw    = v.rw;
        cmd_wdata = v.wdata;
        s0 = start_cnt;
        p0 = stop_cnt;
        @(posedge clk); #1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_ready_low"}, {31'd0, cmd_ready}, 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 2000) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_cycles"}, cyc, v.exp_cyc);
        check({tag, "_nack"}, {31'd0, rsp_nack}, {31'd0, v.exp_nack});
        check({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
        check({tag, "_addr_byte"}, {24'd0, addr_byte}, {24'd0, v.exp_abyte});
        check({tag, "_starts"}, start_cnt - s0, 32'd1);
        check({tag, "_stops"}, stop_cnt - p0, 32'd1);
        check({tag, "_ready_done"}, {31'd0, cmd_ready}, 32'd1);
        if (v.present && v.addr == sl_addr) begin
            check({tag, "_data_byte"}, {24'd0, data_byte},
                  {24'd0, (v.rw ? v.sl_rdata : v.wdata)});
            if (v.rw) check({tag, "_master_nack"}, {31'd0, mack}, 32'd1);
        end
        @(posedge clk); #1;
        check({tag, "_pulse_one"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int p0;
        int s0;

        vecs[0] = '{7'h2A, 1'b0, 8'h5C, 1'b1, 1'b0, 8'h00, 321, 1'b0, 8'h00, 8'h54};
        vecs[1] = '{7'h2A, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5, 321, 1'b0, 8'hA5, 8'h55};
        vecs[2] = '{7'h11, 1'b0, 8'h5C, 1'b1, 1'b0, 8'h00, 177, 1'b1, 8'hA5, 8'h22};
        vecs[3] = '{7'h11, 1'b1, 8'h00, 1'b1, 1'b0, 8'h77, 177, 1'b1, 8'hA5, 8'h23};
        vecs[4] = '{7'h2A, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 321, 1'b1, 8'hA5, 8'h54};
        vecs[5] = '{7'h2A, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00, 321, 1'b0, 8'hA5, 8'h54};
        vecs[6] = '{7'h2A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 321, 1'b0, 8'h3C, 8'h55};
        vecs[7] = '{7'h2A, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 177, 1'b1, 8'h3C, 8'h55};

        // Reset held for 5 clocks
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda", {31'd0, sda_w}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_nack", {31'd0, rsp_nack}, 32'd0);
        check("rst_scl_idle", {31'd0, scl}, 32'd1);
        check("rst_no_rsp", rsp_cnt, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: cmd_valid held high, second command taken in the rsp_valid cycle
        sl_present = 1'b1;
        sl_rdata   = 8'h96;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h2A;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h5C;
        @(posedge clk); #1;
        cyc = 0;
        while (!rsp_valid && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_first_cycles", cyc, 32'd321);
        check("b2b_first_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_rw = 1'b1;
        s0 = start_cnt;
        @(posedge clk); #1;
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        check("b2b_second_ready", {31'd0, cmd_ready}, 32'd0);
        check("b2b_pulse_one", {31'd0, rsp_valid}, 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 2000) begin
            @(negedge clk);
            cmd_valid = (cyc == 50);
            cmd_addr  = (cyc == 50) ? 7'h11 : 7'h2A;
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_second_cycles", cyc, 32'd321);
        check("b2b_second_rdata", {24'd0, rsp_rdata}, 32'h96);
        check("b2b_second_abyte", {24'd0, addr_byte}, 32'h55);
        check("b2b_second_starts", start_cnt - s0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("b2b_no_extra", {31'd0, busy}, 32'd0);

        // Reset at tick 30 of a write
        sl_present = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h2A;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h5C;
        @(posedge clk); #1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (121) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        p0 = rsp_cnt;
        @(posedge clk); #1;
        check("mid_scl", {31'd0, scl}, 32'd1);
        check("mid_sda", {31'd0, sda_w}, 32'd1);
        check("mid_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_busy_low", {31'd0, busy}, 32'd0);
        check("mid_rdata", {24'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("mid_no_rsp", rsp_cnt - p0, 32'd0);
        check("mid_idle", {31'd0, busy}, 32'd0);

        run_txn('{7'h2A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h0F, 321, 1'b0, 8'h0F, 8'h55}, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Single-master I2C transaction sequencer that drives the bus shared with the team's I2C slave blocks. It accepts one command per handshake: 7-bit target address, R/W bit and one write byte. It then generates START, the address/RW byte, the ACK slot, one data byte, the ACK/NACK slot and STOP. It returns read data and an acknowledge status on a one-cycle response strobe. It is the bus-side controller used by test harnesses and by the system host to configure and poll slave devices.

Parameters:
DIV, 25, system clocks per SCL quarter-period (SCL period = 4*DIV clocks); legal range 2..1023
DIV_W, 10, width of the quarter-period counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset
cmd_valid  input  1  command request
cmd_ready  output  1  controller idle and able to accept a command
cmd_addr  input  7  target device address
cmd_rw  input  1  0 = write, 1 = read
cmd_wdata  input  8  byte to write (ignored on read)
rsp_valid  output  1  one-cycle pulse: transaction finished
rsp_rdata  output  8  byte read (valid with rsp_valid on reads)
rsp_nack  output  1  1 = address or write-data slot was NACKed
busy  output  1  transaction in progress
scl  output  1  I2C clock, push-pull, no clock stretching
sda  inout  1  I2C data, open-drain: driven 0 when sda_en, else Z

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state IDLE; scl=1; sda released; cmd_ready=1; busy=0; rsp_valid=0; rsp_rdata=0; rsp_nack=0; all counters 0.
- Reset mid-transaction: the bus is released (scl=1, sda Z) on the first clock with rst_n low. No STOP is generated and no rsp_valid is issued.
- Tick generator: the quarter counter runs only while busy. It counts 0..DIV-1 and emits a one-clock tick on wrap. All bus phase changes happen on ticks.
- Bit slot = 4 quarters q0..q3.
  - q0, q1: scl=0; SDA is updated at the q0 tick.
  - q2, q3: scl=1; SDA is sampled at the tick that ends q2.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_addr/cmd_rw/cmd_wdata are latched that cycle. On the next cycle cmd_ready=0, busy=1 and the state becomes START. cmd_valid while busy is ignored (held off by cmd_ready=0).
- FSM states and transitions:
  - IDLE -> START on accept.
  - START (4 quarters): q0–q1 sda Z, scl 1; q2 sda 0, scl 1; q3 sda 0, scl 0. -> ADDR.
  - ADDR (8 slots): shift {addr,rw} out MSB first; 3-bit bit counter; after bit 0 -> AACK.
  - AACK (1 slot): sda released; sampled 1 sets rsp_nack=1 -> STOP; sampled 0 -> WDATA if rw=0, else RDATA.
  - WDATA (8 slots): cmd_wdata MSB first -> WACK.
  - WACK (1 slot): sda released; sample; rsp_nack=sampled value -> STOP.
  - RDATA (8 slots): sda released; sampled bits shift into rsp_rdata MSB first -> RNACK.
  - RNACK (1 slot): master leaves sda released (NACK, last byte) -> STOP.
  - STOP (4 quarters): q0 scl 0, sda 0; q1 scl 1, sda 0; q2–q3 scl 1, sda Z. -> IDLE.
- Completion: on the clock after STOP's final tick, the FSM returns to IDLE, rsp_valid=1 for exactly one cycle, busy=0 and cmd_ready=1.
  - A new command may be accepted in that same cycle.
  - rsp_rdata and rsp_nack hold until the next accept, where rsp_nack clears to 0.
- Duration: full transaction = 20 slots = 80 ticks = 80*DIV clocks from accept to rsp_valid (+1 clock). Address NACK = 11 slots = 44*DIV (+1).
- On a write, rsp_rdata is unchanged. On an address NACK, rsp_rdata is unchanged.
- SDA only transitions while scl=0, except in START/STOP as listed.

Test Plan:
- Reset held 5 clocks, then released -> scl=1, sda Z, cmd_ready=1, busy=0, rsp_valid never pulses.
- DIV=4, write addr 7'h2A, data 8'h5C to a bench slave that ACKs -> bus shows START, 0x54, ACK, 0x5C, ACK, STOP. rsp_valid at clock 321 after accept; rsp_nack=0.
- DIV=4, read addr 7'h2A, slave returns 8'hA5 -> byte 0x55 on bus, master NACKs the data slot, rsp_rdata=8'hA5, rsp_nack=0, 321 clocks.
- DIV=4, write to 7'h11 with no slave responding -> STOP immediately after the address ACK slot. rsp_valid at clock 177, rsp_nack=1.
- cmd_valid held high across two transactions -> second accepted in the rsp_valid cycle; cmd_valid pulses mid-transaction are ignored.
- rst_n low at tick 30 of a write -> next clock scl=1, sda Z, cmd_ready=1, no rsp_valid; a subsequent command completes normally.
